// File: rtl/dp_mux4_rrarb_pkg.sv
// Shared types and helpers for the dp_mux4ds round-robin arbiters.
// Holds the state encoding, the counter width and the index decode used for the one-cold selects.
package dp_mux4_rrarb_pkg;

  typedef enum logic {
    RR_IDLE  = 1'b0,
    RR_OWNED = 1'b1
  } rr_state_e;

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [3:0] idx_to_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // Active-low select lines for a decoded-select mux: exactly one bit low.
  function automatic logic [3:0] idx_to_onecold(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/dp_mux4_rrarb_rr_pick4.sv
// Combinational round-robin picker: first request at or after ptr_i, wrapping, skipping excl_i.
// Zero latency; no backpressure.
module rr_pick4 (
  input  logic [3:0] req_i,
  input  logic [1:0] ptr_i,
  input  logic [3:0] excl_i,
  output logic       valid_o,
  output logic [1:0] idx_o
);

  logic [3:0] cand;
  logic [1:0] probe;

  // Walk from the farthest offset down so the nearest candidate to ptr_i wins.
  always_comb begin
    cand    = req_i & ~excl_i;
    valid_o = 1'b0;
    idx_o   = ptr_i;
    probe   = '0;
    for (int i = 3; i >= 0; i--) begin
      probe = ptr_i + 2'(i);
      if (cand[probe]) begin
        valid_o = 1'b1;
        idx_o   = probe;
      end
    end
  end

endmodule

// File: rtl/dp_mux4_rrarb.sv
// Round-robin owner of one shared dp_mux4ds: registered one-hot grant and one-cold selects, 1-cycle grant/release.
// Tenure bounded by MAX_HOLD while others wait; handoffs are back-to-back with no idle bubble.
module dp_mux4_rrarb
  import dp_mux4_rrarb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic       sel0_l,
  output logic       sel1_l,
  output logic       sel2_l,
  output logic       sel3_l,
  output logic [1:0] owner,
  output logic       busy
);

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
  localparam bit               HOLD_EN  = (MAX_HOLD != 0);

  rr_state_e        state_q, state_d;
  logic [1:0]       owner_q, owner_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [3:0] own_oh;
  logic [3:0] excl;
  logic       pick_vld;
  logic [1:0] pick_idx;

  assign own_oh = idx_to_onehot(owner_q);
  // Excluding the current owner makes "pick valid" mean "someone else is waiting".
  assign excl   = (state_q == RR_OWNED) ? own_oh : 4'b0000;

  rr_pick4 u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .excl_i  (excl),
    .valid_o (pick_vld),
    .idx_o   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      RR_IDLE: begin
        if (pick_vld) begin
          state_d = RR_OWNED;
          owner_d = pick_idx;
          ptr_d   = pick_idx + 2'd1;
          cnt_d   = CNT_W'(1);
        end
      end
      RR_OWNED: begin
        if (!req[owner_q] || (HOLD_EN && (cnt_q >= HOLD_LIM) && pick_vld)) begin
          if (pick_vld) begin
            owner_d = pick_idx;
            ptr_d   = pick_idx + 2'd1;
            cnt_d   = CNT_W'(1);
          end else begin
            state_d = RR_IDLE;
          end
        end else if (HOLD_EN) begin
          // Sole requester: park the counter at the limit so a newcomer preempts promptly.
          if (cnt_q < HOLD_LIM) cnt_d = cnt_q + CNT_W'(1);
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = RR_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RR_IDLE;
      owner_q <= 2'd0;
      ptr_q   <= 2'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode registered state only; nothing from req reaches the selects.
  assign gnt   = (state_q == RR_OWNED) ? own_oh : 4'b0000;
  assign busy  = (state_q == RR_OWNED);
  assign owner = owner_q;
  assign {sel3_l, sel2_l, sel1_l, sel0_l} = idx_to_onecold(owner_q);

endmodule

// File: tb/tb_dp_mux4_rrarb.sv
// Scoreboard bench: three arbiters (hold limits 16, 4, 0) share one request stream and are
// checked every cycle against a tenure-level reference model.
module tb_dp_mux4_rrarb;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = 4'b0000;

  always #5 clk = ~clk;

  logic [3:0] gnt_a, sel_a, gnt_b, sel_b, gnt_c, sel_c;
  logic [1:0] own_a, own_b, own_c;
  logic       busy_a, busy_b, busy_c;

  dp_mux4_rrarb #(.MAX_HOLD(16)) u_dut_a (
    .clk(clk), .reset(reset), .req(req), .gnt(gnt_a),
    .sel0_l(sel_a[0]), .sel1_l(sel_a[1]), .sel2_l(sel_a[2]), .sel3_l(sel_a[3]),
    .owner(own_a), .busy(busy_a)
  );

  dp_mux4_rrarb #(.MAX_HOLD(4)) u_dut_b (
    .clk(clk), .reset(reset), .req(req), .gnt(gnt_b),
    .sel0_l(sel_b[0]), .sel1_l(sel_b[1]), .sel2_l(sel_b[2]), .sel3_l(sel_b[3]),
    .owner(own_b), .busy(busy_b)
  );

  dp_mux4_rrarb #(.MAX_HOLD(0)) u_dut_c (
    .clk(clk), .reset(reset), .req(req), .gnt(gnt_c),
    .sel0_l(sel_c[0]), .sel1_l(sel_c[1]), .sel2_l(sel_c[2]), .sel3_l(sel_c[3]),
    .owner(own_c), .busy(busy_c)
  );

  typedef struct packed {
    logic [3:0] gnt;
    logic [3:0] sel;
    logic [1:0] own;
    logic       busy;
  } obs_t;

  obs_t q0[$];
  obs_t q1[$];
  obs_t q2[$];
  int   n_chk = 0;
  int   n_fail = 0;

  // Reference model: owner -1 means idle; park is the last owner; ten counts cycles of tenure.
  int lim[3] = '{16, 4, 0};
  int m_own[3];
  int m_park[3];
  int m_ten[3];
  int m_ptr[3];

  task automatic m_reset();
    for (int m = 0; m < 3; m++) begin
      m_own[m]  = -1;
      m_park[m] = 0;
      m_ten[m]  = 0;
      m_ptr[m]  = 0;
    end
  endtask

  function automatic int m_find(int m, logic [3:0] r, int excl);
    for (int i = 0; i < 4; i++) begin
      int c;
      c = (m_ptr[m] + i) % 4;
      if (r[c] && c != excl) return c;
    end
    return -1;
  endfunction

  task automatic m_grant(int m, int w);
    m_own[m]  = w;
    m_park[m] = w;
    m_ten[m]  = 1;
    m_ptr[m]  = (w + 1) % 4;
  endtask

  task automatic m_step(int m, logic [3:0] r);
    int k;
    int w;
    k = m_own[m];
    if (k < 0) begin
      w = m_find(m, r, -1);
      if (w >= 0) m_grant(m, w);
    end else begin
      w = m_find(m, r, k);
      if (!r[k]) begin
        if (w >= 0) m_grant(m, w);
        else m_own[m] = -1;
      end else if (lim[m] != 0 && m_ten[m] >= lim[m] && w >= 0) begin
        m_grant(m, w);
      end else begin
        m_ten[m] = m_ten[m] + 1;
      end
    end
  endtask

  function automatic obs_t m_obs(int m);
    obs_t o;
    o.gnt  = (m_own[m] < 0) ? 4'b0000 : 4'(1 << m_own[m]);
    o.sel  = ~4'(1 << m_park[m]);
    o.own  = 2'(m_park[m]);
    o.busy = (m_own[m] >= 0);
    return o;
  endfunction

  task automatic chk(string nm, obs_t act, obs_t exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got gnt=%b sel=%b owner=%0d busy=%b, want gnt=%b sel=%b owner=%0d busy=%b",
               nm, $time, act.gnt, act.sel, act.own, act.busy, exp.gnt, exp.sel, exp.own, exp.busy);
    end
  endtask

  task automatic push_step(logic [3:0] v);
    req = v;
    for (int m = 0; m < 3; m++) m_step(m, v);
    q0.push_back(m_obs(0));
    q1.push_back(m_obs(1));
    q2.push_back(m_obs(2));
  endtask

  task automatic drive(logic [3:0] v);
    @(negedge clk);
    push_step(v);
  endtask

  task automatic chk_reset(string nm);
    obs_t e;
    e = '{gnt: 4'b0000, sel: 4'b1110, own: 2'd0, busy: 1'b0};
    chk({nm, "_h16"}, {gnt_a, sel_a, own_a, busy_a}, e);
    chk({nm, "_h4"},  {gnt_b, sel_b, own_b, busy_b}, e);
    chk({nm, "_h0"},  {gnt_c, sel_c, own_c, busy_c}, e);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) chk("hold16", {gnt_a, sel_a, own_a, busy_a}, q0.pop_front());
      if (q1.size() > 0) chk("hold4",  {gnt_b, sel_b, own_b, busy_b}, q1.pop_front());
      if (q2.size() > 0) chk("hold0",  {gnt_c, sel_c, own_c, busy_c}, q2.pop_front());
    end
  end

  initial begin
    logic [3:0] r;
    m_reset();
    #12;
    chk_reset("reset_init");
    @(negedge clk);
    reset = 1'b0;

    // Lone requester held well past every hold limit.
    repeat (24) drive(4'b0100);
    repeat (2) drive(4'b0000);

    // All requesting; each owner drops for one cycle after three grant cycles.
    repeat (24) begin
      r = 4'hF;
      if (m_own[0] >= 0 && m_ten[0] >= 3) r[m_own[0]] = 1'b0;
      drive(r);
    end
    repeat (2) drive(4'b0000);

    // Requester 2 arrives while 0 holds; 0 keeps requesting and is re-granted afterwards.
    repeat (2) drive(4'b0001);
    repeat (8) drive(4'b0101);
    repeat (4) drive(4'b0001);
    repeat (2) drive(4'b0000);

    // Park on 3 when idle, then a fresh request.
    repeat (3) drive(4'b1000);
    repeat (3) drive(4'b0000);
    repeat (2) drive(4'b0001);
    drive(4'b0000);

    // Long contention between 0 and 1.
    repeat (30) drive(4'b0011);
    drive(4'b0000);

    // Random requests with sticky bits so tenures run long enough to reach the limits.
    r = 4'b0000;
    repeat (600) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(7) == 0) r[b] = ~r[b];
      drive(r);
    end

    // Reset mid-tenure, then re-arbitration from index 0.
    repeat (3) drive(4'b0110);
    @(negedge clk);
    reset = 1'b1;
    req   = 4'hF;
    #1;
    chk_reset("reset_async");
    @(posedge clk);
    #1;
    chk_reset("reset_held");
    @(negedge clk);
    reset = 1'b0;
    m_reset();
    push_step(4'hF);
    repeat (10) drive(4'hF);
    repeat (2) drive(4'b0000);

    repeat (2) @(posedge clk);
    #3;
    if (q0.size() + q1.size() + q2.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q0.size() + q1.size() + q2.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
